// File: rtl/raster_scan_gen.sv
// raster_scan_gen: raster (x, y) coordinate source for the Sobel datapath.
// Emits a valid/ready stream of pixel positions with SOF/EOL/EOF markers,
// stalls on downstream back-pressure and supports single or continuous frames.
// Optional blanking gaps between lines/frames are built only when the macro
// RASTER_BLANK_EN is defined; otherwise lines and frames run back to back.
module raster_scan_gen #(
  parameter int WIDTH_P    = 16,
  parameter int H_ACTIVE_P = 640,
  parameter int V_ACTIVE_P = 480,
  parameter int H_BLANK_P  = 16,
  parameter int V_BLANK_P  = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               cont_i,
  input  logic               abort_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [WIDTH_P-1:0] x_o,
  output logic [WIDTH_P-1:0] y_o,
  output logic               sof_o,
  output logic               eol_o,
  output logic               eof_o,
  output logic               busy_o,
  output logic [WIDTH_P-1:0] frame_cnt_o
);

  // Geometry sanity check at elaboration; blank lengths are checked even when
  // the gaps are compiled out so a bad configuration is caught in every build.
  if (H_ACTIVE_P < 1 || V_ACTIVE_P < 1 || H_BLANK_P < 0 || V_BLANK_P < 0 ||
      H_ACTIVE_P >= (2 ** WIDTH_P) || V_ACTIVE_P >= (2 ** WIDTH_P)) begin : g_bad_param
    $error("raster_scan_gen: invalid geometry parameters");
  end

  localparam logic [WIDTH_P-1:0] X_LAST = WIDTH_P'(H_ACTIVE_P - 1);
  localparam logic [WIDTH_P-1:0] Y_LAST = WIDTH_P'(V_ACTIVE_P - 1);

`ifdef RASTER_BLANK_EN
  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_e;

  // Blank counters hold N-1 down to 0, so ceil(log2(N+1)) bits, at least 1.
  localparam int HCW = (H_BLANK_P > 0) ? $clog2(H_BLANK_P + 1) : 1;
  localparam int VCW = (V_BLANK_P > 0) ? $clog2(V_BLANK_P + 1) : 1;

  logic [HCW-1:0] hcnt_q;
  logic [VCW-1:0] vcnt_q;
  logic           cont_q;   // cont_i captured at the EOF transfer
`else
  typedef enum logic {IDLE, ACTIVE} state_e;
`endif

  state_e             state_q;
  logic [WIDTH_P-1:0] x_q, y_q, fcnt_q;
  logic               at_eol, at_eof;

  assign at_eol = (x_q == X_LAST);
  assign at_eof = at_eol && (y_q == Y_LAST);

  // Scan FSM: position, frame count and blank timing all advance here.
  // In ACTIVE valid_o is high, so ready_i alone marks a transfer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      fcnt_q  <= '0;
`ifdef RASTER_BLANK_EN
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      cont_q  <= 1'b0;
`endif
    end else if (abort_i) begin
      // Abort wins over everything; a coincident EOF transfer is not counted.
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ACTIVE;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        ACTIVE: begin
          if (ready_i) begin
            if (!at_eol) begin
              x_q <= x_q + WIDTH_P'(1);
            end else if (!at_eof) begin
              x_q <= '0;
              y_q <= y_q + WIDTH_P'(1);
`ifdef RASTER_BLANK_EN
              if (H_BLANK_P > 0) begin
                state_q <= HBLANK;
                hcnt_q  <= HCW'(H_BLANK_P - 1);
              end
`endif
            end else begin
              x_q    <= '0;
              y_q    <= '0;
              fcnt_q <= fcnt_q + WIDTH_P'(1);
`ifdef RASTER_BLANK_EN
              cont_q <= cont_i;
              if (V_BLANK_P > 0) begin
                state_q <= VBLANK;
                vcnt_q  <= VCW'(V_BLANK_P - 1);
              end else if (!cont_i) begin
                state_q <= IDLE;
              end
`else
              if (!cont_i) state_q <= IDLE;
`endif
            end
          end
        end
`ifdef RASTER_BLANK_EN
        // Blank cycles elapse regardless of ready_i.
        HBLANK: begin
          if (hcnt_q == '0) state_q <= ACTIVE;
          else              hcnt_q  <= hcnt_q - HCW'(1);
        end
        VBLANK: begin
          if (vcnt_q == '0) state_q <= cont_q ? ACTIVE : IDLE;
          else              vcnt_q  <= vcnt_q - VCW'(1);
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state and position, so they stay
  // stable across a stall.
  assign valid_o     = (state_q == ACTIVE);
  assign busy_o      = (state_q != IDLE);
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign frame_cnt_o = fcnt_q;
  assign sof_o       = valid_o && (x_q == '0) && (y_q == '0);
  assign eol_o       = valid_o && at_eol;
  assign eof_o       = valid_o && at_eof;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Bench for raster_scan_gen: directed sequence of frames with ready patterns
// (always, 1-0-0-1, random), continuous mode, abort, async reset and ignored
// start. Expected beats come from frame arithmetic on a beat index.
module tb_raster_scan_gen;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int HB = 2;
  localparam int VB = 3;
  localparam int HV = H * V;
`ifdef RASTER_BLANK_EN
  localparam int HB_E = HB;
  localparam int VB_E = VB;
`else
  localparam int HB_E = 0;
  localparam int VB_E = 0;
`endif

  logic         clk = 1'b0, rstn = 1'b0;
  logic         start = 1'b0, cont = 1'b0, abort = 1'b0, ready = 1'b0;
  logic         valid, sof, eol, eof, busy;
  logic [W-1:0] x, y, fc;
  int           n_cmp = 0, n_err = 0;
  int           fc_exp = 0;

  always #5 clk = ~clk;

  raster_scan_gen #(
    .WIDTH_P(W), .H_ACTIVE_P(H), .V_ACTIVE_P(V), .H_BLANK_P(HB), .V_BLANK_P(VB)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .cont_i(cont), .abort_i(abort),
    .ready_i(ready), .valid_o(valid), .x_o(x), .y_o(y), .sof_o(sof), .eol_o(eol),
    .eof_o(eof), .busy_o(busy), .frame_cnt_o(fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_x"},     32'(x), 0);
    chk({tag, "_y"},     32'(y), 0);
    chk({tag, "_flags"}, 32'({sof, eol, eof}), 0);
    chk({tag, "_fcnt"},  32'(fc), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Accept beats k0..kend-1. rmode: 0 ready always, 1 ready 1,0,0,1 repeating,
  // 2 random. cont_i is held high for all but the last of nframes frames.
  task automatic run_beats(input int k0, input int kend, input int rmode, input int nframes);
    int k = k0, gap = 0, cyc = 0, exp_gap;
    bit pend = 0, stalled = 0;
    logic [W-1:0] hx = '0, hy = '0;
    logic [2:0]   hf = '0;
    while (k < kend) begin
      @(negedge clk);
      cyc++;
      if (cyc > 40 * (kend - k0) + 100) begin
        chk("beat_timeout", 32'(k), 32'(kend));
        return;
      end
      cont = ((k / HV) < nframes - 1);
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        chk("hold_valid", 32'(valid), 1);
        chk("hold_xy",    32'({x, y}), 32'({hx, hy}));
        chk("hold_flags", 32'({sof, eol, eof}), 32'(hf));
      end
      if (valid) begin
        if (!pend) begin
          if (k == k0)          exp_gap = 0;
          else if (k % HV == 0) exp_gap = VB_E;
          else if (k % H == 0)  exp_gap = HB_E;
          else                  exp_gap = 0;
          chk("gap", 32'(gap), 32'(exp_gap));
          chk("frame_cnt", 32'(fc), 32'(fc_exp % (1 << W)));
          gap  = 0;
          pend = 1;
        end
        if (ready) begin
          chk("x",   32'(x), 32'((k % HV) % H));
          chk("y",   32'(y), 32'((k % HV) / H));
          chk("sof", 32'(sof), 32'(k % HV == 0));
          chk("eol", 32'(eol), 32'(k % H == H - 1));
          chk("eof", 32'(eof), 32'(k % HV == HV - 1));
          if (k % HV == HV - 1) fc_exp++;
          k++;
          pend    = 0;
          stalled = 0;
        end else begin
          stalled = 1;
          hx = x; hy = y; hf = {sof, eol, eof};
        end
      end else begin
        gap++;
        stalled = 0;
      end
    end
  endtask

  // After the final EOF: count busy cycles (the frame gap) until IDLE.
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    ready = 1'($urandom_range(0, 1));
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
      ready = 1'($urandom_range(0, 1));
    end
    chk("vblank_len", 32'(n), 32'(VB_E));
    chk("idle_valid", 32'(valid), 0);
    chk("idle_xy",    32'({x, y}), 0);
    chk("idle_fcnt",  32'(fc), 32'(fc_exp % (1 << W)));
  endtask

  initial begin
    // Reset state
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_reset");

    // Single frame, ready always high
    pulse_start();
    run_beats(0, HV, 0, 1);
    wait_idle();

    // Ready 1,0,0,1 back-pressure
    pulse_start();
    run_beats(0, HV, 1, 1);
    wait_idle();

    // Two continuous frames (frame gap checked at beat 12)
    pulse_start();
    run_beats(0, 2 * HV, 0, 2);
    wait_idle();

    // Random back-pressure, two continuous frames
    pulse_start();
    run_beats(0, 2 * HV, 2, 2);
    wait_idle();

    // Abort with a coincident transfer at beat (2,1)
    pulse_start();
    run_beats(0, 6, 0, 1);
    @(negedge clk);
    ready = 1'b1;
    chk("abort_at_valid", 32'(valid), 1);
    chk("abort_at_xy", 32'({x, y}), 32'({8'd2, 8'd1}));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(valid), 0);
    chk("abort_busy",  32'(busy), 0);
    chk("abort_xy",    32'({x, y}), 0);
    chk("abort_fcnt",  32'(fc), 32'(fc_exp % (1 << W)));
    pulse_start();
    run_beats(0, HV, 2, 1);
    wait_idle();

    // start_i while busy is ignored, then async reset mid-line-gap
    pulse_start();
    run_beats(0, 5, 0, 1);
    @(negedge clk);
    ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_xy", 32'({x, y}), 32'({8'd1, 8'd1}));
    run_beats(5, 8, 0, 1);
    @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 1);
    #2 rstn = 1'b0;
    #1 chk_reset_vals("async_reset");
    fc_exp = 0;
    @(negedge clk);
    rstn = 1'b1;

    // Recovery after reset
    pulse_start();
    run_beats(0, HV, 2, 1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
